data_mem_unit: RTL and testbench
================================

Name: data_mem_unit

Overview:
Parametrised, byte-addressable, little-endian data memory for the pipeline MEM stage. Replaces the 128-byte combinational-read store with a registered, handshaked unit. Supports lb/lh/lw/lbu/lhu and sb/sh/sw, with configurable depth. Accesses that cross a word boundary are either split into two beats by an FSM or faulted. Out-of-range and illegal accesses report a fault code instead of silently wrapping.

Parameters:
ADDR_WIDTH, 10, byte-address bits implemented; memory size = 2**ADDR_WIDTH bytes, organised as 2**(ADDR_WIDTH-2) 32-bit words with 4 byte lanes.
MISALIGN_SPLIT, 1, 1 = word-crossing access executed as two beats; 0 = word-crossing access faults.
INIT_PATTERN, 1, 1 = byte i initialised to i[7:0] at time zero; 0 = initialised to 0.

Ports:
Clk  in  1  clock, all state updates on rising edge
Reset  in  1  synchronous active-high reset
Req_Valid  in  1  request present
Req_Ready  out  1  unit can accept a request this cycle
Req_Is_Store  in  1  1 = store, 0 = load
Req_Variant  in  3  funct3: 000 b, 001 h, 010 w, 100 bu, 101 hu
Req_Addr  in  32  byte address
Req_Wdata  in  32  store data, low bytes used per size
Resp_Valid  out  1  one-cycle completion pulse, no backpressure
Resp_Data  out  32  load result, sign- or zero-extended; 0 for stores and faults
Resp_Fault  out  2  00 ok, 01 misaligned, 10 out of range, 11 illegal variant

Behaviour:
- Reset: Clk and Reset behave as decided above: one clock; reset is synchronous and active-high. On a Reset edge, state goes to IDLE, Resp_Valid=0, Resp_Data=0 and Resp_Fault=00. Memory contents are not cleared; memory is initialised only at time zero, per INIT_PATTERN.
- Accept: a request is accepted on a rising edge where Req_Valid=1, Req_Ready=1 and Reset=0. Req_Ready=1 exactly when state=IDLE.
- Size: b=1, h=2, w=4 bytes. The first byte is at A=Req_Addr and the last byte is at A+size-1.
- Decode priority, evaluated at accept:
  - Illegal variant gives fault 11. This covers loads with 011, 110 or 111, and stores with any variant other than 000, 001 or 010.
  - Otherwise, if Req_Addr[31:ADDR_WIDTH] is nonzero, or A+size-1 is 2**ADDR_WIDTH or more, the access gives fault 10. Addresses never wrap.
  - Otherwise, if the access crosses a word boundary (A[1:0]+size > 4) and MISALIGN_SPLIT=0, it gives fault 01.
  - A faulted access never writes memory. It produces Resp_Valid one cycle after accept, with Resp_Data=0.
- Non-crossing access (including misaligned accesses that stay within one word):
  - Stores write only the addressed byte lanes at the accept edge.
  - Loads read the word and extract and extend bytes A..A+size-1.
  - Resp_Valid is asserted in the cycle after accept (latency 1).
  - The unit stays in IDLE, so back-to-back accepts give throughput of 1 per cycle.
- Crossing access with MISALIGN_SPLIT=1:
  - IDLE→SPLIT at accept. Latch the request and the low-word bytes; stores write the low-word lanes at the accept edge.
  - SPLIT: Req_Ready=0. The unit accesses word index+1. Stores write the remaining high lanes at that edge; loads merge the high bytes.
  - SPLIT→IDLE on the next edge. Resp_Valid is asserted the cycle after that (latency 2).
- Load extension:
  - lb and lh sign-extend from bit 7 and bit 15 respectively.
  - lbu and lhu zero-extend.
  - Byte order is little-endian: byte A is bits 7:0.
- Resp_Valid is high for exactly one cycle per accepted request. Responses are returned in order.
- Read-after-write: a load accepted the cycle after a store observes the stored data.
- Reset during SPLIT: the FSM is abandoned and no response is produced. Low-word lanes already written stay written; there is no rollback.
- Reset has priority over a simultaneous Req_Valid; that request is not accepted.

Test Plan:
- INIT_PATTERN=1, lw at 0x08 → Resp_Valid 1 cycle after accept, Resp_Data=0x0B0A0908, fault 00; 4 back-to-back lw at 0,4,8,12 → 4 consecutive Resp_Valid pulses.
- lb at 0x80 → 0xFFFFFF80; lbu at 0x80 → 0x00000080; lhu at 0xFE → 0x0000FFFE; lh at 0xFE → 0xFFFFFFFE.
- MISALIGN_SPLIT=1: lh at 0x03 → Req_Ready low 1 cycle, Resp_Data=0x00000403 at latency 2. sw 0xDEADBEEF at 0x06, then lw at 0x06 → 0xDEADBEEF; bytes 6..9 = EF,BE,AD,DE; bytes 5 and 10 unchanged.
- ADDR_WIDTH=10: lw at 0x3FE → fault 10, no write. sw at 0x400 → fault 10, memory unchanged. Load with variant 011 → fault 11, Resp_Data=0.
- MISALIGN_SPLIT=0: lw at 0x05 → fault 01 at latency 1. sh at 0x05 (no crossing) → succeeds, writing bytes 5 and 6.
- Reset asserted in the SPLIT cycle of sw 0x11223344 at 0x06 → no Resp_Valid; bytes 6,7 = 44,33; bytes 8,9 = 08,09; Req_Ready=1 next cycle.

Source files
------------

// File: rtl/data_mem_unit.sv
// data_mem_unit
// -----------------------------------------------------------------------------
// Byte-addressable, little-endian data memory for the MEM stage.
// 2**ADDR_WIDTH bytes, stored as 2**(ADDR_WIDTH-2) 32-bit words with 4 byte
// lanes. Supports lb/lh/lw/lbu/lhu and sb/sh/sw. Accesses that cross a word
// boundary are executed as two beats (MISALIGN_SPLIT=1) or faulted (=0).
// Out-of-range addresses and illegal variants return a fault code.
//
// Handshake: a request is accepted on a rising edge of Clk where
// Req_Valid=1, Req_Ready=1 and Reset=0. Req_Ready is high exactly while the
// unit is idle. Every accepted request yields exactly one Resp_Valid pulse
// (no backpressure), in request order: one cycle after accept for single-word
// accesses and faults, two cycles after accept for split accesses.
//
// Ports:
//   Clk          clock, all state updates on rising edge
//   Reset        synchronous active-high reset
//   Req_Valid    request present
//   Req_Ready    unit can accept a request this cycle
//   Req_Is_Store 1 = store, 0 = load
//   Req_Variant  funct3: 000 b, 001 h, 010 w, 100 bu, 101 hu
//   Req_Addr     byte address
//   Req_Wdata    store data, low bytes used per size
//   Resp_Valid   one-cycle completion pulse
//   Resp_Data    load result, extended; 0 for stores and faults
//   Resp_Fault   00 ok, 01 misaligned, 10 out of range, 11 illegal variant
//   dbg_state    current FSM state (0 = IDLE, 1 = SPLIT)
// -----------------------------------------------------------------------------
module data_mem_unit #(
  parameter int ADDR_WIDTH     = 10,
  parameter bit MISALIGN_SPLIT = 1'b1,
  parameter bit INIT_PATTERN   = 1'b1
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Req_Valid,
  output logic        Req_Ready,
  input  logic        Req_Is_Store,
  input  logic [2:0]  Req_Variant,
  input  logic [31:0] Req_Addr,
  input  logic [31:0] Req_Wdata,
  output logic        Resp_Valid,
  output logic [31:0] Resp_Data,
  output logic [1:0]  Resp_Fault,
  output logic        dbg_state
);

  localparam int IW    = ADDR_WIDTH - 2;
  localparam int WORDS = 2 ** IW;

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_SPLIT = 1'b1
  } state_t;

  localparam logic [1:0] F_OK    = 2'b00;
  localparam logic [1:0] F_ALIGN = 2'b01;
  localparam logic [1:0] F_RANGE = 2'b10;
  localparam logic [1:0] F_ILL   = 2'b11;

  // Memory image loaded at time zero only; reset never clears it.
  function automatic logic [WORDS-1:0][31:0] init_mem();
    logic [WORDS-1:0][31:0] m;
    for (int w = 0; w < WORDS; w++) begin
      for (int b = 0; b < 4; b++) begin
        m[w][b*8 +: 8] = INIT_PATTERN ? 8'(w * 4 + b) : 8'h00;
      end
    end
    return m;
  endfunction

  // Shift the addressed bytes down to bit 0 and sign/zero extend.
  function automatic logic [31:0] extend_load(input logic [63:0] pair,
                                              input logic [1:0]  off,
                                              input logic [2:0]  variant);
    logic [63:0] sh;
    logic [31:0] res;
    sh = pair >> {off, 3'b000};
    case (variant)
      3'b000:  res = {{24{sh[7]}}, sh[7:0]};
      3'b001:  res = {{16{sh[15]}}, sh[15:0]};
      3'b100:  res = {24'h0, sh[7:0]};
      3'b101:  res = {16'h0, sh[15:0]};
      default: res = sh[31:0];
    endcase
    return res;
  endfunction

  logic [WORDS-1:0][31:0] mem = init_mem();

  state_t state_q, state_d;

  // Request decode
  logic [2:0]            size;
  logic [2:0]            size_m1;
  logic [3:0]            size_mask;
  logic                  illegal;
  logic [ADDR_WIDTH:0]   last_addr;
  logic                  out_of_range;
  logic                  crosses;
  logic [1:0]            dec_fault;
  logic [7:0]            ext_mask;
  logic [63:0]           ext_data;
  logic                  accept;
  logic                  go_split;

  // Request latched for the second beat
  logic                  st_q;
  logic [2:0]            var_q;
  logic [1:0]            off_q;
  logic [IW-1:0]         idx_q;
  logic [31:0]           lo_q;
  logic [3:0]            hi_mask_q;
  logic [31:0]           hi_data_q;

  // Single memory port
  logic [IW-1:0]         rd_idx;
  logic [31:0]           rd_word;
  logic                  wr_en;
  logic [IW-1:0]         wr_idx;
  logic [3:0]            wr_mask;
  logic [31:0]           wr_data;

  assign Req_Ready = (state_q == S_IDLE);
  assign dbg_state = state_q;
  assign accept    = Req_Valid & Req_Ready & ~Reset;

  always_comb begin
    size      = 3'd4;
    size_mask = 4'b1111;
    case (Req_Variant[1:0])
      2'b00: begin size = 3'd1; size_mask = 4'b0001; end
      2'b01: begin size = 3'd2; size_mask = 4'b0011; end
      default: begin size = 3'd4; size_mask = 4'b1111; end
    endcase
  end

  always_comb begin
    illegal = 1'b0;
    if (Req_Is_Store) begin
      illegal = !(Req_Variant == 3'b000 || Req_Variant == 3'b001 ||
                  Req_Variant == 3'b010);
    end else begin
      illegal = (Req_Variant == 3'b011 || Req_Variant == 3'b110 ||
                 Req_Variant == 3'b111);
    end
  end

  // The sum is one bit wider than the implemented address space, so a carry
  // into bit ADDR_WIDTH means the last byte lies beyond the memory.
  assign size_m1      = size - 3'd1;
  assign last_addr    = {1'b0, Req_Addr[ADDR_WIDTH-1:0]} +
                        {{(ADDR_WIDTH-2){1'b0}}, size_m1};
  assign out_of_range = (|Req_Addr[31:ADDR_WIDTH]) | last_addr[ADDR_WIDTH];
  assign crosses      = ({2'b00, Req_Addr[1:0]} + {1'b0, size}) > 4'd4;

  always_comb begin
    dec_fault = F_OK;
    if (illegal) begin
      dec_fault = F_ILL;
    end else if (out_of_range) begin
      dec_fault = F_RANGE;
    end else if (crosses && !MISALIGN_SPLIT) begin
      dec_fault = F_ALIGN;
    end
  end

  // Lane mask and data spread over two consecutive words; the upper half
  // is only non-zero for word-crossing accesses.
  assign ext_mask = {4'b0000, size_mask} << Req_Addr[1:0];
  assign ext_data = {32'h0, Req_Wdata} << {Req_Addr[1:0], 3'b000};
  assign go_split = accept && (dec_fault == F_OK) && crosses;

  // FSM: state register
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (go_split) state_d = S_SPLIT;
      S_SPLIT: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Second-beat context
  always_ff @(posedge Clk) begin
    if (go_split) begin
      st_q      <= Req_Is_Store;
      var_q     <= Req_Variant;
      off_q     <= Req_Addr[1:0];
      idx_q     <= Req_Addr[ADDR_WIDTH-1:2];
      lo_q      <= rd_word;
      hi_mask_q <= ext_mask[7:4];
      hi_data_q <= ext_data[63:32];
    end
  end

  // Memory port: in SPLIT the port serves the next word of the latched
  // request, otherwise the word addressed by the incoming request.
  assign rd_idx  = (state_q == S_SPLIT) ? idx_q + {{(IW-1){1'b0}}, 1'b1}
                                        : Req_Addr[ADDR_WIDTH-1:2];
  assign rd_word = mem[rd_idx];

  always_comb begin
    wr_en   = 1'b0;
    wr_idx  = rd_idx;
    wr_mask = 4'b0000;
    wr_data = 32'h0;
    if (state_q == S_SPLIT) begin
      // A reset in this cycle abandons the high lanes; low lanes stay written.
      if (st_q && !Reset) begin
        wr_en   = 1'b1;
        wr_mask = hi_mask_q;
        wr_data = hi_data_q;
      end
    end else if (accept && (dec_fault == F_OK) && Req_Is_Store) begin
      wr_en   = 1'b1;
      wr_mask = ext_mask[3:0];
      wr_data = ext_data[31:0];
    end
  end

  always_ff @(posedge Clk) begin
    if (wr_en) begin
      for (int l = 0; l < 4; l++) begin
        if (wr_mask[l]) begin
          mem[wr_idx][l*8 +: 8] <= wr_data[l*8 +: 8];
        end
      end
    end
  end

  // Response register
  always_ff @(posedge Clk) begin
    if (Reset) begin
      Resp_Valid <= 1'b0;
      Resp_Data  <= 32'h0;
      Resp_Fault <= F_OK;
    end else begin
      Resp_Valid <= 1'b0;
      Resp_Data  <= 32'h0;
      Resp_Fault <= F_OK;
      if (state_q == S_SPLIT) begin
        Resp_Valid <= 1'b1;
        Resp_Data  <= st_q ? 32'h0 : extend_load({rd_word, lo_q}, off_q, var_q);
      end else if (accept) begin
        if (dec_fault != F_OK) begin
          Resp_Valid <= 1'b1;
          Resp_Fault <= dec_fault;
        end else if (!crosses) begin
          Resp_Valid <= 1'b1;
          Resp_Data  <= Req_Is_Store ? 32'h0
                        : extend_load({32'h0, rd_word}, Req_Addr[1:0], Req_Variant);
        end
      end
    end
  end

endmodule

// File: tb/tb_data_mem_unit.sv
// tb_data_mem_unit
// -----------------------------------------------------------------------------
// Self-checking bench for data_mem_unit. Two instances: dut 0 splits
// word-crossing accesses, dut 1 faults them. Both use the byte-index memory
// image. Drivers push {expected cycle, fault, data} into a per-dut queue; the
// monitors pop and compare whenever Resp_Valid is seen.
// -----------------------------------------------------------------------------
module tb_data_mem_unit;

  typedef struct packed {
    logic [31:0] cyc;
    logic [1:0]  fault;
    logic [31:0] data;
  } exp_t;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [1:0]  rst;
  logic [1:0]  valid;
  logic [1:0]  is_store;
  logic [2:0]  variant [2];
  logic [31:0] addr    [2];
  logic [31:0] wdata   [2];
  logic [1:0]  ready;
  logic [1:0]  rvalid;
  logic [31:0] rdata   [2];
  logic [1:0]  rfault  [2];
  logic [1:0]  dbg;

  data_mem_unit #(.ADDR_WIDTH(10), .MISALIGN_SPLIT(1'b1), .INIT_PATTERN(1'b1)) dut0 (
    .Clk(clk), .Reset(rst[0]), .Req_Valid(valid[0]), .Req_Ready(ready[0]),
    .Req_Is_Store(is_store[0]), .Req_Variant(variant[0]), .Req_Addr(addr[0]),
    .Req_Wdata(wdata[0]), .Resp_Valid(rvalid[0]), .Resp_Data(rdata[0]),
    .Resp_Fault(rfault[0]), .dbg_state(dbg[0])
  );

  data_mem_unit #(.ADDR_WIDTH(10), .MISALIGN_SPLIT(1'b0), .INIT_PATTERN(1'b1)) dut1 (
    .Clk(clk), .Reset(rst[1]), .Req_Valid(valid[1]), .Req_Ready(ready[1]),
    .Req_Is_Store(is_store[1]), .Req_Variant(variant[1]), .Req_Addr(addr[1]),
    .Req_Wdata(wdata[1]), .Resp_Valid(rvalid[1]), .Resp_Data(rdata[1]),
    .Resp_Fault(rfault[1]), .dbg_state(dbg[1])
  );

  // scoreboard
  exp_t  exp_q0 [$];
  exp_t  exp_q1 [$];
  string name_q0 [$];
  string name_q1 [$];
  int    n_cmp = 0;
  int    n_fail = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, required 0x%08h", nm, act, req);
    end
  endtask

  task automatic check_resp(input int d);
    exp_t  e;
    string nm;
    int    qsz;
    qsz = (d == 0) ? exp_q0.size() : exp_q1.size();
    if (qsz == 0) begin
      n_cmp++;
      n_fail++;
      $display("FAIL unexpected_resp dut%0d: Resp_Valid=1 at cycle %0d, required no response", d, cyc);
      return;
    end
    if (d == 0) begin
      e = exp_q0.pop_front();
      nm = name_q0.pop_front();
    end else begin
      e = exp_q1.pop_front();
      nm = name_q1.pop_front();
    end
    check({nm, "/data"}, rdata[d], e.data);
    check({nm, "/fault"}, {30'h0, rfault[d]}, {30'h0, e.fault});
    check({nm, "/cycle"}, cyc, e.cyc);
  endtask

  // monitors
  always @(negedge clk) if (rvalid[0] === 1'b1) check_resp(0);
  always @(negedge clk) if (rvalid[1] === 1'b1) check_resp(1);

  // driver tasks: called just after a rising edge; return just after the
  // accepting edge with the request still driven.
  task automatic req(input int d, input bit st, input logic [2:0] v,
                     input logic [31:0] a, input logic [31:0] wd,
                     input logic [31:0] ed, input logic [1:0] ef,
                     input int lat, input string nm, input bit expect_resp = 1'b1);
    int   guard;
    exp_t e;
    guard = 0;
    valid[d] = 1'b1;
    is_store[d] = st;
    variant[d] = v;
    addr[d] = a;
    wdata[d] = wd;
    while (ready[d] !== 1'b1 && guard < 20) begin
      @(posedge clk);
      #1;
      guard++;
    end
    if (guard >= 20) begin
      n_cmp++;
      n_fail++;
      $display("FAIL %s/ready_timeout: Req_Ready=%b, required 1 within 20 cycles", nm, ready[d]);
      valid[d] = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    if (expect_resp) begin
      e.cyc = 32'(cyc + lat - 1);
      e.fault = ef;
      e.data = ed;
      if (d == 0) begin
        exp_q0.push_back(e);
        name_q0.push_back(nm);
      end else begin
        exp_q1.push_back(e);
        name_q1.push_back(nm);
      end
    end
  endtask

  task automatic idle(input int n);
    valid = 2'b00;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    n_fail++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    rst = 2'b11;
    valid = 2'b00;
    is_store = 2'b00;
    for (int i = 0; i < 2; i++) begin
      variant[i] = 3'b010;
      addr[i] = 32'h0;
      wdata[i] = 32'h0;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      check($sformatf("reset_valid%0d", i), {31'h0, rvalid[i]}, 32'h0);
      check($sformatf("reset_data%0d", i), rdata[i], 32'h0);
      check($sformatf("reset_fault%0d", i), {30'h0, rfault[i]}, 32'h0);
    end
    rst = 2'b00;
    @(posedge clk);
    #1;
    check("reset_ready0", {31'h0, ready[0]}, 32'h1);
    check("reset_ready1", {31'h0, ready[1]}, 32'h1);

    // ---------------- dut 0 (split) ----------------
    req(0, 1'b0, 3'b010, 32'h08, 32'h0, 32'h0B0A0908, 2'b00, 1, "lw_08");
    idle(2);
    // back-to-back words: consecutive cycles are enforced by the cycle check
    req(0, 1'b0, 3'b010, 32'h00, 32'h0, 32'h03020100, 2'b00, 1, "b2b_lw_00");
    req(0, 1'b0, 3'b010, 32'h04, 32'h0, 32'h07060504, 2'b00, 1, "b2b_lw_04");
    req(0, 1'b0, 3'b010, 32'h08, 32'h0, 32'h0B0A0908, 2'b00, 1, "b2b_lw_08");
    req(0, 1'b0, 3'b010, 32'h0C, 32'h0, 32'h0F0E0D0C, 2'b00, 1, "b2b_lw_0c");
    idle(2);
    // extension
    req(0, 1'b0, 3'b000, 32'h80, 32'h0, 32'hFFFFFF80, 2'b00, 1, "lb_80");
    req(0, 1'b0, 3'b100, 32'h80, 32'h0, 32'h00000080, 2'b00, 1, "lbu_80");
    req(0, 1'b0, 3'b101, 32'hFE, 32'h0, 32'h0000FFFE, 2'b00, 1, "lhu_fe");
    req(0, 1'b0, 3'b001, 32'hFE, 32'h0, 32'hFFFFFFFE, 2'b00, 1, "lh_fe");
    req(0, 1'b0, 3'b000, 32'h3FF, 32'h0, 32'hFFFFFFFF, 2'b00, 1, "lb_3ff");
    idle(2);
    // split load: ready low for exactly one cycle
    req(0, 1'b0, 3'b001, 32'h03, 32'h0, 32'h00000403, 2'b00, 2, "lh_03_split");
    check("split_ready_low", {31'h0, ready[0]}, 32'h0);
    check("split_dbg_state", {31'h0, dbg[0]}, 32'h1);
    idle(1);
    check("split_ready_back", {31'h0, ready[0]}, 32'h1);
    idle(2);
    // reset during the SPLIT cycle of a store: low lanes stay, no response
    req(0, 1'b1, 3'b010, 32'h06, 32'h11223344, 32'h0, 2'b00, 2, "sw_06_reset", 1'b0);
    valid[0] = 1'b0;
    rst[0] = 1'b1;
    @(posedge clk);
    #1;
    rst[0] = 1'b0;
    check("rst_split_ready", {31'h0, ready[0]}, 32'h1);
    idle(3);
    req(0, 1'b0, 3'b010, 32'h04, 32'h0, 32'h33440504, 2'b00, 1, "rst_low_lanes");
    req(0, 1'b0, 3'b010, 32'h08, 32'h0, 32'h0B0A0908, 2'b00, 1, "rst_high_lanes");
    idle(2);
    // split store then split load of the same word pair
    req(0, 1'b1, 3'b010, 32'h06, 32'hDEADBEEF, 32'h0, 2'b00, 2, "sw_06");
    req(0, 1'b0, 3'b010, 32'h06, 32'h0, 32'hDEADBEEF, 2'b00, 2, "lw_06");
    req(0, 1'b0, 3'b010, 32'h04, 32'h0, 32'hBEEF0504, 2'b00, 1, "lw_04_after_sw");
    req(0, 1'b0, 3'b010, 32'h08, 32'h0, 32'h0B0ADEAD, 2'b00, 1, "lw_08_after_sw");
    idle(2);
    // range faults, no writes, no wrap
    req(0, 1'b0, 3'b010, 32'h3FE, 32'h0, 32'h0, 2'b10, 1, "lw_3fe_range");
    req(0, 1'b1, 3'b010, 32'h400, 32'h55555555, 32'h0, 2'b10, 1, "sw_400_range");
    req(0, 1'b1, 3'b010, 32'h3FE, 32'h55555555, 32'h0, 2'b10, 1, "sw_3fe_range");
    req(0, 1'b0, 3'b000, 32'h80000000, 32'h0, 32'h0, 2'b10, 1, "lb_high_range");
    req(0, 1'b0, 3'b010, 32'h3FC, 32'h0, 32'hFFFEFDFC, 2'b00, 1, "lw_3fc_unchanged");
    req(0, 1'b0, 3'b010, 32'h00, 32'h0, 32'h03020100, 2'b00, 1, "lw_00_no_wrap");
    // illegal variants, with priority over range
    req(0, 1'b0, 3'b011, 32'h00, 32'h0, 32'h0, 2'b11, 1, "ld_011_illegal");
    req(0, 1'b1, 3'b100, 32'h00, 32'h12345678, 32'h0, 2'b11, 1, "st_100_illegal");
    req(0, 1'b0, 3'b111, 32'h400, 32'h0, 32'h0, 2'b11, 1, "ld_111_oor_illegal");
    req(0, 1'b0, 3'b010, 32'h00, 32'h0, 32'h03020100, 2'b00, 1, "lw_00_after_ill");
    idle(2);

    // ---------------- dut 1 (fault on crossing) ----------------
    req(1, 1'b0, 3'b010, 32'h05, 32'h0, 32'h0, 2'b01, 1, "lw_05_misalign");
    req(1, 1'b0, 3'b101, 32'h07, 32'h0, 32'h0, 2'b01, 1, "lhu_07_misalign");
    req(1, 1'b0, 3'b010, 32'h3FE, 32'h0, 32'h0, 2'b10, 1, "lw_3fe_range1");
    req(1, 1'b1, 3'b001, 32'h05, 32'h0000A5B6, 32'h0, 2'b00, 1, "sh_05");
    req(1, 1'b0, 3'b010, 32'h04, 32'h0, 32'h07A5B604, 2'b00, 1, "lw_04_after_sh");
    req(1, 1'b0, 3'b010, 32'h08, 32'h0, 32'h0B0A0908, 2'b00, 1, "lw_08_dut1");
    idle(6);

    check("drain_q0", exp_q0.size(), 32'h0);
    check("drain_q1", exp_q1.size(), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
